fifo_reader: RTL and testbench

Read-side controller for the 10-bit data FIFO.
- Watches the FIFO's `empty` flag, issues `pop`, and captures the FIFO's registered `data_out` one cycle later into a 2-entry skid buffer.
- Presents captured words downstream on a valid/ready handshake, so downstream backpressure never loses or duplicates a word.
- Sits between each FIFO instance and its consumer, and obeys the same 4-bit one-hot `state` control bus the FIFO receives.

---
 rtl/fifo_rd_pkg.sv | 23 ++
 rtl/fifo_rd_if.sv | 34 +++
 rtl/fifo_rd_skid.sv | 87 ++++++++
 rtl/fifo_reader.sv | 127 ++++++++++++
 tb/tb_fifo_reader.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side controller: control-bus codes,
// default widths and the internal operating-mode encoding.
package fifo_rd_pkg;

    localparam int DATA_WIDTH_DEF = 10;
    localparam int CNT_WIDTH_DEF  = 8;

    localparam logic [3:0] ST_RESET  = 4'b0001;
    localparam logic [3:0] ST_INIT   = 4'b0010;
    localparam logic [3:0] ST_IDLE   = 4'b0100;
    localparam logic [3:0] ST_ACTIVE = 4'b1000;

    localparam logic [1:0] SKID_DEPTH = 2'd2;

    // CLEAR and FLUSH both empty the pipeline; HOLD drains without popping.
    typedef enum logic [1:0] {
        MODE_CLEAR = 2'd0,
        MODE_FLUSH = 2'd1,
        MODE_HOLD  = 2'd2,
        MODE_RUN   = 2'd3
    } rd_mode_e;

endpackage

// File: rtl/fifo_rd_if.sv
// FIFO read port plus downstream valid/ready stream of the read controller.
// The master side is the controller; the slave side is FIFO + consumer.
interface fifo_rd_if
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  fifo_empty,
        input  fifo_data_out,
        input  out_ready,
        output fifo_pop,
        output out_data,
        output out_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_data_out,
        output out_ready,
        input  fifo_pop,
        input  out_data,
        input  out_valid
    );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer: head register feeds the consumer, tail register
// absorbs the word that was already in flight when backpressure arrived.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] head_r;
    logic [DATA_WIDTH-1:0] tail_r;
    logic [DATA_WIDTH-1:0] head_nxt_s;
    logic [DATA_WIDTH-1:0] tail_nxt_s;
    logic [1:0]            occ_r;
    logic [1:0]            occ_nxt_s;
    logic                  rd_s;

    // Next-state of the buffer for every write/read combination
    always_comb begin
        head_nxt_s = head_r;
        tail_nxt_s = tail_r;
        occ_nxt_s  = occ_r;
        rd_s       = rd_en && (occ_r != 2'd0);
        if (flush) begin
            head_nxt_s = '0;
            tail_nxt_s = '0;
            occ_nxt_s  = 2'd0;
        end else begin
            case ({wr_en, rd_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        head_nxt_s = wr_data;
                        occ_nxt_s  = 2'd1;
                    end else if (occ_r == 2'd1) begin
                        tail_nxt_s = wr_data;
                        occ_nxt_s  = 2'd2;
                    end else begin
                        // Full: the pop rule never lets a word arrive here.
                        occ_nxt_s = occ_r;
                    end
                end
                2'b01: begin
                    head_nxt_s = tail_r;
                    occ_nxt_s  = occ_r - 2'd1;
                end
                2'b11: begin
                    // Oldest word leaves; the arriving word lands behind whatever remains.
                    if (occ_r == 2'd1) begin
                        head_nxt_s = wr_data;
                    end else begin
                        head_nxt_s = tail_r;
                        tail_nxt_s = wr_data;
                    end
                    occ_nxt_s = occ_r;
                end
                default: begin
                    occ_nxt_s = occ_r;
                end
            endcase
        end
    end

    // Buffer storage and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r <= '0;
            tail_r <= '0;
            occ_r  <= 2'd0;
        end else begin
            head_r <= head_nxt_s;
            tail_r <= tail_nxt_s;
            occ_r  <= occ_nxt_s;
        end
    end

    assign occ  = occ_r;
    assign head = head_r;

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller for the data FIFO: pop/in-flight tracking, control-bus
// decode, delivered-word counter. FIFO_RD_PARITY_EN enables the even-parity check.
module fifo_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           state,
    fifo_rd_if.master            bus,
    output logic                 idle,
    output logic [CNT_WIDTH-1:0] pop_count,
    output logic                 parity_err
);

    rd_mode_e              mode_s;
    logic                  clear_s;
    logic                  run_s;
    logic                  valid_s;
    logic                  deq_s;
    logic                  capture_s;
    logic                  pop_s;
    logic                  inflight_r;
    logic [1:0]            occ_s;
    logic [2:0]            load_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic [CNT_WIDTH-1:0]  count_r;

    // Decode the control bus; reset wins and unknown codes behave as IDLE
    always_comb begin
        mode_s = MODE_HOLD;
        if (reset) begin
            mode_s = MODE_CLEAR;
        end else begin
            case (state)
                ST_RESET:  mode_s = MODE_CLEAR;
                ST_INIT:   mode_s = MODE_FLUSH;
                ST_IDLE:   mode_s = MODE_HOLD;
                ST_ACTIVE: mode_s = MODE_RUN;
                default:   mode_s = MODE_HOLD;
            endcase
        end
    end

    assign clear_s   = (mode_s == MODE_CLEAR) || (mode_s == MODE_FLUSH);
    assign run_s     = (mode_s == MODE_RUN);
    assign valid_s   = (occ_s != 2'd0);
    assign deq_s     = valid_s && bus.out_ready;
    assign capture_s = inflight_r && !clear_s;
    // Words that will occupy the skid after this edge, excluding a new pop.
    assign load_s    = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, deq_s};

    // Pop only while active, data is available and a slot is guaranteed
    always_comb begin
        pop_s = 1'b0;
        if (run_s && !bus.fifo_empty && (load_s < {1'b0, SKID_DEPTH})) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // A pop sampled by the FIFO returns its word on the next edge
    always_ff @(posedge clk) begin
        if (clear_s) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= pop_s;
        end
    end

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .flush   (clear_s),
        .wr_en   (capture_s),
        .wr_data (bus.fifo_data_out),
        .rd_en   (deq_s),
        .occ     (occ_s),
        .head    (head_s)
    );

    // Delivered-word counter, wraps naturally at its width
    always_ff @(posedge clk) begin
        if (clear_s) begin
            count_r <= '0;
        end else if (deq_s) begin
            count_r <= count_r + CNT_WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

`ifdef FIFO_RD_PARITY_EN
    logic parity_err_r;

    function automatic logic parity_bad(input logic [DATA_WIDTH-1:0] word);
        return ^word;
    endfunction

    // Sticky flag set on the edge a word with odd parity is captured
    always_ff @(posedge clk) begin
        if (clear_s) begin
            parity_err_r <= 1'b0;
        end else if (capture_s && parity_bad(bus.fifo_data_out)) begin
            parity_err_r <= 1'b1;
        end else begin
            parity_err_r <= parity_err_r;
        end
    end

    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    assign idle          = (occ_s == 2'd0) && !inflight_r && (bus.fifo_empty || !run_s);
    assign pop_count     = count_r;
    assign bus.fifo_pop  = pop_s;
    assign bus.out_valid = valid_s;
    assign bus.out_data  = head_s;

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: FIFO model plus a queue-based scoreboard
// of popped-but-undelivered words, driven by directed and random phases.
module tb_fifo_reader;

    localparam int DW = 10;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    state;
    logic          idle;
    logic [CW-1:0] pop_count;
    logic          parity_err;

    fifo_rd_if #(.DATA_WIDTH(DW)) bus ();

    fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .bus        (bus),
        .idle       (idle),
        .pop_count  (pop_count),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic          last_pop = 1'b0;
    logic [DW-1:0] pend_word = '0;
    logic [CW-1:0] exp_cnt = '0;
    logic          exp_perr = 1'b0;
    int            pops_seen = 0;
    logic          obs_valid;
    logic [DW-1:0] obs_data;
    logic          obs_idle;
    logic          obs_perr;
    logic [DW-1:0] last_deliv = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] gen_word();
        logic [DW-1:0] w;
        w = DW'($urandom);
`ifdef FIFO_RD_PARITY_EN
        w[DW-1] = ^w[DW-2:0];
`endif
        return w;
    endfunction

    // One clock cycle: drive at negedge, check at negedge+1, update model at posedge.
    task automatic cycle(input logic rst_i, input logic [3:0] st_i, input logic rdy_i);
        logic run_b, clr_b, exp_valid, exp_deq, exp_pop, exp_idle, obs_pop;
        int   vis;
        logic [DW-1:0] w;
        @(negedge clk);
        reset             = rst_i;
        state             = st_i;
        bus.out_ready     = rdy_i;
        bus.fifo_empty    = (fifo_q.size() == 0);
        bus.fifo_data_out = last_pop ? pend_word : DW'($urandom);
        #1;
        run_b     = !rst_i && (st_i == 4'b1000);
        clr_b     = rst_i || (st_i == 4'b0001) || (st_i == 4'b0010);
        vis       = exp_q.size() - (last_pop ? 1 : 0);
        exp_valid = (vis > 0);
        exp_deq   = exp_valid && rdy_i;
        exp_pop   = run_b && (fifo_q.size() != 0) && ((exp_q.size() - (exp_deq ? 1 : 0)) < 2);
        exp_idle  = (exp_q.size() == 0) && ((fifo_q.size() == 0) || !run_b);
        obs_pop   = bus.fifo_pop;
        obs_valid = bus.out_valid;
        obs_data  = bus.out_data;
        obs_idle  = idle;
        obs_perr  = parity_err;
        chk("fifo_pop", 32'(obs_pop), 32'(exp_pop));
        chk("out_valid", 32'(obs_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("out_data", 32'(obs_data), 32'(exp_q[0]));
        end
        chk("idle", 32'(obs_idle), 32'(exp_idle));
        chk("pop_count", 32'(pop_count), 32'(exp_cnt));
        chk("parity_err", 32'(obs_perr), 32'(exp_perr));
        if (obs_valid && rdy_i) begin
            last_deliv = obs_data;
        end
        if (obs_pop) begin
            pops_seen++;
        end
        @(posedge clk);
        if (clr_b) begin
            exp_q.delete();
            last_pop = 1'b0;
            exp_cnt  = '0;
            exp_perr = 1'b0;
        end else begin
`ifdef FIFO_RD_PARITY_EN
            if (last_pop && (^exp_q[$])) begin
                exp_perr = 1'b1;
            end
`endif
            if (exp_deq) begin
                void'(exp_q.pop_front());
                exp_cnt = exp_cnt + 8'd1;
            end
            if (obs_pop && (fifo_q.size() != 0)) begin
                w = fifo_q.pop_front();
                exp_q.push_back(w);
                pend_word = w;
                last_pop  = 1'b1;
            end else begin
                last_pop = 1'b0;
            end
        end
    endtask

    initial begin
        logic [3:0] odd_codes [5];
        logic [DW-1:0] first_w;
        int r;
        odd_codes[0] = 4'b0000;
        odd_codes[1] = 4'b0011;
        odd_codes[2] = 4'b0101;
        odd_codes[3] = 4'b1111;
        odd_codes[4] = 4'b1100;

        reset             = 1'b1;
        state             = 4'b0001;
        bus.out_ready     = 1'b0;
        bus.fifo_empty    = 1'b1;
        bus.fifo_data_out = '0;
        @(posedge clk);

        // Reset held two cycles
        repeat (2) cycle(1'b1, 4'b0001, 1'b0);
        chk("rst_out_data", 32'(obs_data), 32'd0);
        chk("rst_idle", 32'(obs_idle), 32'd1);

        // Preloaded 1..9 streamed with out_ready high
        for (int i = 1; i <= 9; i++) fifo_q.push_back(DW'(i));
        repeat (13) cycle(1'b0, 4'b1000, 1'b1);
        chk("stream_count", 32'(pop_count), 32'd9);
        chk("stream_last", 32'(last_deliv), 32'd9);

        // Backpressure: four words queued, consumer stalled five cycles
        for (int i = 0; i < 4; i++) fifo_q.push_back(gen_word());
        first_w   = fifo_q[0];
        pops_seen = 0;
        repeat (5) cycle(1'b0, 4'b1000, 1'b0);
        chk("bp_pops", 32'(pops_seen), 32'd2);
        chk("bp_valid", 32'(obs_valid), 32'd1);
        chk("bp_head", 32'(obs_data), 32'(first_w));
        repeat (8) cycle(1'b0, 4'b1000, 1'b1);

        // ACTIVE -> IDLE right after a pop
        for (int i = 0; i < 3; i++) fifo_q.push_back(gen_word());
        cycle(1'b0, 4'b1000, 1'b1);
        pops_seen = 0;
        repeat (5) cycle(1'b0, 4'b0100, 1'b1);
        chk("idle_pops", 32'(pops_seen), 32'd0);
        chk("idle_flag", 32'(obs_idle), 32'd1);

        // Reset, then INIT, in the cycle after a pop
        cycle(1'b0, 4'b1000, 1'b0);
        cycle(1'b1, 4'b1000, 1'b0);
        cycle(1'b0, 4'b0100, 1'b0);
        chk("rst_drop_valid", 32'(obs_valid), 32'd0);
        cycle(1'b0, 4'b1000, 1'b0);
        cycle(1'b0, 4'b0010, 1'b0);
        cycle(1'b0, 4'b0100, 1'b0);
        chk("init_drop_valid", 32'(obs_valid), 32'd0);

        // FIFO running dry mid-stream with overlapping pushes
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) fifo_q.push_back(gen_word());
            cycle(1'b0, 4'b1000, 1'b1);
        end

        // Long stream to exercise counter wrap
        for (int i = 0; i < 300; i++) fifo_q.push_back(gen_word());
        repeat (306) cycle(1'b0, 4'b1000, 1'b1);

        // Random mix of control codes, backpressure and pushes
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 15);
            if ($urandom_range(0, 7) < 3) fifo_q.push_back(gen_word());
            if ($urandom_range(0, 7) == 0) fifo_q.push_back(gen_word());
            if ($urandom_range(0, 63) == 0) begin
                cycle(1'b1, 4'b1000, 1'($urandom));
            end else if (r == 0) begin
                cycle(1'b0, 4'b0010, 1'($urandom));
            end else if (r == 1) begin
                cycle(1'b0, odd_codes[$urandom_range(0, 4)], 1'($urandom));
            end else if (r < 5) begin
                cycle(1'b0, 4'b0100, 1'($urandom));
            end else begin
                cycle(1'b0, 4'b1000, 1'($urandom));
            end
        end
        repeat (8) cycle(1'b0, 4'b1000, 1'b1);

`ifdef FIFO_RD_PARITY_EN
        // Odd-parity word: flag sticks until INIT, word still delivered
        cycle(1'b0, 4'b0010, 1'b0);
        fifo_q.delete();
        fifo_q.push_back(10'b0000000001);
        repeat (4) cycle(1'b0, 4'b1000, 1'b1);
        chk("par_set", 32'(obs_perr), 32'd1);
        chk("par_word", 32'(last_deliv), 32'd1);
        repeat (3) cycle(1'b0, 4'b0100, 1'b1);
        chk("par_sticky", 32'(obs_perr), 32'd1);
        cycle(1'b0, 4'b0010, 1'b0);
        cycle(1'b0, 4'b0100, 1'b0);
        chk("par_clear", 32'(obs_perr), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
